// File: rtl/iq_decim_buf.sv
// iq_decim_buf: decimates filtered baseband I/Q by DECIM at a run-time
// selectable sample phase and buffers the result in a first-word-fall-through
// FIFO with a ready/valid output.
// Build option: define DECIM_AVG_EN to replace sample picking with a boxcar
// average over each decimation window.
module iq_decim_buf #(
    parameter int WI         = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 16,
    localparam int PW        = $clog2(DECIM),
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WI-1:0] I_in,
    input  logic [WI-1:0] Q_in,
    input  logic          iq_in_val,
    input  logic [PW-1:0] phase_in,
    input  logic          phase_ld,
    output logic [WI-1:0] I_out,
    output logic [WI-1:0] Q_out,
    output logic          iq_out_val,
    input  logic          iq_out_rdy,
    output logic [LW-1:0] level,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [WI-1:0] last_i_q, last_i_d;
    logic [WI-1:0] last_q_q, last_q_d;

    logic [WI-1:0] mem_i [FIFO_DEPTH];
    logic [WI-1:0] mem_q [FIFO_DEPTH];

    logic          sel, pop, full, wr_en, drop;
    logic [WI-1:0] wr_i, wr_q;
    logic [WI-1:0] head_i, head_q;

    // A sample is taken when the valid-input count lands on the programmed phase;
    // the phase register in use is the pre-load value.
    assign sel    = iq_in_val && (cnt_q == phase_q);
    assign full   = (level_q == LW'(FIFO_DEPTH));
    assign pop    = iq_out_val && iq_out_rdy;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en  = sel && (!full || pop);
    assign drop   = sel && full && !pop;
    assign head_i = mem_i[rd_ptr_q];
    assign head_q = mem_q[rd_ptr_q];

`ifdef DECIM_AVG_EN
    logic signed [WI+PW-1:0] acc_i_q, acc_i_d, sum_i;
    logic signed [WI+PW-1:0] acc_q_q, acc_q_d, sum_q;

    // Window sum including the current sample; >>> PW then truncation to WI
    // is simply the upper WI bits of the sum (floor division by DECIM).
    always_comb begin
        sum_i   = acc_i_q + {{PW{I_in[WI-1]}}, I_in};
        sum_q   = acc_q_q + {{PW{Q_in[WI-1]}}, Q_in};
        wr_i    = sum_i[WI+PW-1:PW];
        wr_q    = sum_q[WI+PW-1:PW];
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        if (iq_in_val) begin
            acc_i_d = sel ? '0 : sum_i;
            acc_q_d = sel ? '0 : sum_q;
        end
        // A new phase starts a fresh (possibly short) window.
        if (phase_ld) begin
            acc_i_d = '0;
            acc_q_d = '0;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end
`else
    // Pick mode: selected samples pass bit-exact.
    always_comb begin
        wr_i = I_in;
        wr_q = Q_in;
    end
`endif

    // Next-state for phase tracking, FIFO pointers, occupancy and flags.
    always_comb begin
        cnt_d    = iq_in_val ? cnt_q + 1'b1 : cnt_q;
        phase_d  = phase_ld ? phase_in : phase_q;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + LW'(wr_en) - LW'(pop);
        ovf_d    = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
        last_i_d = pop ? head_i : last_i_q;
        last_q_d = pop ? head_q : last_q_q;
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            last_i_q <= '0;
            last_q_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            last_i_q <= last_i_d;
            last_q_q <= last_q_d;
        end
    end

    // FIFO storage; contents are don't-care outside the pointer window.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_i[wr_ptr_q] <= wr_i;
            mem_q[wr_ptr_q] <= wr_q;
        end
    end

    // Head is shown while non-empty; otherwise the last popped sample holds.
    always_comb begin
        iq_out_val = (level_q != '0);
        I_out      = iq_out_val ? head_i : last_i_q;
        Q_out      = iq_out_val ? head_q : last_q_q;
        level      = level_q;
        ovf        = ovf_q;
    end

endmodule

// File: tb/tb_iq_decim_buf.sv
// Self-checking bench for iq_decim_buf: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_iq_decim_buf;

    localparam int WI    = 16;
    localparam int DECIM = 4;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DECIM);
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [WI-1:0] I_in = '0, Q_in = '0;
    logic          iq_in_val = 1'b0;
    logic [PW-1:0] phase_in = '0;
    logic          phase_ld = 1'b0;
    logic [WI-1:0] I_out, Q_out;
    logic          iq_out_val;
    logic          iq_out_rdy = 1'b0;
    logic [LW-1:0] level;
    logic          ovf;
    logic          ovf_clr = 1'b0;

    iq_decim_buf #(.WI(WI), .DECIM(DECIM), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .I_in(I_in), .Q_in(Q_in), .iq_in_val(iq_in_val),
        .phase_in(phase_in), .phase_ld(phase_ld), .I_out(I_out), .Q_out(Q_out),
        .iq_out_val(iq_out_val), .iq_out_rdy(iq_out_rdy), .level(level),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: expected state after the most recent edge.
    int  m_fifo_i[$];
    int  m_fifo_q[$];
    int  m_nvalid;      // valid inputs seen since reset
    int  m_phase;
    int  m_last_i, m_last_q;
    bit  m_ovf;
    int  m_sum_i, m_sum_q;
    bit  chk_en = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, $signed(obs), $signed(exp), $time);
        end
    endtask

    function automatic int fdiv(input int a);
        return (a >= 0) ? a / DECIM : -((-a + DECIM - 1) / DECIM);
    endfunction

    task automatic check_all();
        int n;
        n = m_fifo_i.size();
        chk("val",   32'(iq_out_val), 32'(n != 0));
        chk("level", 32'(level), n);
        chk("ovf",   32'(ovf), 32'(m_ovf));
        chk("I_out", 32'($signed(I_out)), (n != 0) ? m_fifo_i[0] : m_last_i);
        chk("Q_out", 32'($signed(Q_out)), (n != 0) ? m_fifo_q[0] : m_last_q);
    endtask

    task automatic model_reset();
        m_fifo_i.delete();
        m_fifo_q.delete();
        m_nvalid = 0; m_phase = 0;
        m_last_i = 0; m_last_q = 0;
        m_ovf = 0; m_sum_i = 0; m_sum_q = 0;
    endtask

    // One clock: check the previous edge's result, then drive and predict.
    task automatic step(input bit r, input bit v, input int si, input int sq,
                        input bit ld, input int ph, input bit rdy, input bit clr);
        bit sel, pop, drop;
        int wi, wq, n;
        @(negedge clk);
        if (chk_en) check_all();
        rst = r; iq_in_val = v; I_in = WI'(si); Q_in = WI'(sq);
        phase_ld = ld; phase_in = PW'(ph); iq_out_rdy = rdy; ovf_clr = clr;
        if (r) begin
            model_reset();
        end else begin
            sel = v && ((m_nvalid % DECIM) == m_phase);
`ifdef DECIM_AVG_EN
            wi = fdiv(m_sum_i + si);
            wq = fdiv(m_sum_q + sq);
`else
            wi = si;
            wq = sq;
`endif
            n    = m_fifo_i.size();
            pop  = (n != 0) && rdy;
            drop = 0;
            if (pop) begin
                m_last_i = m_fifo_i.pop_front();
                m_last_q = m_fifo_q.pop_front();
            end
            if (sel) begin
                if (n < DEPTH || pop) begin
                    m_fifo_i.push_back(wi);
                    m_fifo_q.push_back(wq);
                end else drop = 1;
            end
            if (drop) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (v) begin
                m_nvalid++;
                if (sel) begin m_sum_i = 0; m_sum_q = 0; end
                else begin m_sum_i += si; m_sum_q += sq; end
            end
            if (ld) begin
                m_phase = ph;
                m_sum_i = 0; m_sum_q = 0;
            end
        end
    endtask

    // Look at the DUT just after the edge that consumed the last step.
    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    initial begin
        int si, sq;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;

        // Ramp, phase 0, with a phase change to 2 after five inputs.
        for (int k = 0; k < 16; k++) begin
            step(0, 1, k, -k, (k == 5), 2, 1, 0);
`ifndef DECIM_AVG_EN
            if (k == 4) begin
                peek();
                chk("ramp_I4", 32'($signed(I_out)), 4);
                chk("ramp_Q4", 32'($signed(Q_out)), -4);
                chk("ramp_lvl", 32'(level), 1);
            end
            if (k == 6) begin
                peek();
                chk("ld_I6", 32'($signed(I_out)), 6);
            end
`endif
        end
        idle(3, 1);

        // Gapped valid, phase 3.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 1, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, k, 100 + k, 0, 0, 1, 0);
`ifndef DECIM_AVG_EN
            if (k == 3) begin
                peek();
                chk("gap_I3", 32'($signed(I_out)), 3);
            end
`endif
            idle(2, 1);
        end

        // Overflow: 17 selected samples with the output stalled.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17 * DECIM; k++) step(0, 1, k, -k, 0, 0, 0, 0);
        peek();
        chk("ovf_lvl", 32'(level), DEPTH);
        chk("ovf_set", 32'(ovf), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        peek();
        chk("ovf_clr", 32'(ovf), 0);
        // Full with simultaneous pop: write accepted, no overflow.
        step(0, 1, 999, -999, 0, 0, 1, 0);
        peek();
        chk("fullpop_lvl", 32'(level), DEPTH);
        chk("fullpop_ovf", 32'(ovf), 0);
        idle(DEPTH + 2, 1);

`ifdef DECIM_AVG_EN
        // Boxcar averaging, phase 3.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 1, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0);
        step(0, 1, 2, 0, 0, 0, 1, 0);
        step(0, 1, 3, 0, 0, 0, 1, 0);
        step(0, 1, 5, 0, 0, 0, 1, 0);
        peek();
        chk("avg_pos", 32'($signed(I_out)), 2);
        step(0, 1, -1, 0, 0, 0, 1, 0);
        step(0, 1, -1, 0, 0, 0, 1, 0);
        step(0, 1, -1, 0, 0, 0, 1, 0);
        step(0, 1, -2, 0, 0, 0, 1, 0);
        peek();
        chk("avg_floor", 32'($signed(I_out)), -2);
        step(0, 1, 7, 7, 0, 0, 0, 0);
        step(0, 1, 7, 7, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        peek();
        chk("avg_rst_lvl", 32'(level), 0);
        chk("avg_rst_val", 32'(iq_out_val), 0);
        step(0, 1, 4, 8, 0, 0, 1, 0);
        peek();
        chk("avg_rst_acc", 32'($signed(I_out)), 1);
`endif

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
`ifdef DECIM_AVG_EN
            si = int'($urandom_range(8191)) - 4096;
            sq = int'($urandom_range(8191)) - 4096;
`else
            si = int'($signed(WI'($urandom())));
            sq = int'($signed(WI'($urandom())));
`endif
            step(($urandom_range(299) == 0), ($urandom_range(9) < 6), si, sq,
                 ($urandom_range(19) == 0), int'($urandom_range(DECIM - 1)),
                 ($urandom_range(9) < 4), ($urandom_range(29) == 0));
        end
        @(negedge clk);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
